// File: rtl/fetch_stage_ctrl.sv
// Fetch stage: PC register plus IF/ID register, driven by the hazard/branch controls.
// Latency: pc_out is registered, and inst_in reaches if_id_inst one cycle after its pc_out.
// Backpressure: pc_write/ir_write freeze each register independently. Saturating stall/flush counters and a stall watchdog are kept for debug.
module fetch_stage_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CNT_W     = 16,
  parameter int          MAX_STALL = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pc_write,
  input  logic             ir_write,
  input  logic             flush,
  input  logic             pc_src,
  input  logic             jmp,
  input  logic [31:0]      branch_target,
  input  logic [31:0]      jump_target,
  input  logic [31:0]      inst_in,
  output logic [31:0]      pc_out,
  output logic [31:0]      if_id_inst,
  output logic [31:0]      if_id_pc4,
  output logic             if_id_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             stall_timeout
);

  // The watchdog counter only needs to reach MAX_STALL, where it parks.
  localparam int             WD_W   = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(MAX_STALL);

  logic [31:0]      r_pc;
  logic [31:0]      r_if_id_inst;
  logic [31:0]      r_if_id_pc4;
  logic             r_if_id_valid;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [WD_W-1:0]  r_wd_cnt;
  logic             r_stall_timeout;

  logic [31:0]      w_pc_plus4;
  logic [31:0]      w_pc_next;
  logic             w_stall;
  logic             w_flush_applied;
  logic [WD_W-1:0]  w_wd_next;

  // A stall means both registers are frozen; a flush only counts when IF/ID actually takes the bubble.
  assign w_pc_plus4      = r_pc + 32'd4;
  assign w_stall         = ~pc_write & ~ir_write;
  assign w_flush_applied = flush & ir_write;

  // Next-PC selection: a hold beats any redirect, and jump beats branch.
  always_comb begin
    w_pc_next = w_pc_plus4;
    if (!pc_write) begin
      w_pc_next = r_pc;
    end else if (jmp) begin
      w_pc_next = jump_target;
    end else if (pc_src) begin
      w_pc_next = branch_target;
    end
  end

  // Watchdog next value: it counts consecutive stalls, saturates at MAX_STALL, and clears on any other cycle.
  always_comb begin
    w_wd_next = '0;
    if (w_stall) begin
      w_wd_next = (r_wd_cnt == WD_MAX) ? r_wd_cnt : r_wd_cnt + 1'b1;
    end
  end

  // PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  // IF/ID register: a hold beats flush, so a flush arriving during a stall is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_id_inst  <= '0;
      r_if_id_pc4   <= '0;
      r_if_id_valid <= 1'b0;
    end else if (ir_write) begin
      if (flush) begin
        r_if_id_inst  <= '0;
        r_if_id_pc4   <= '0;
        r_if_id_valid <= 1'b0;
      end else begin
        r_if_id_inst  <= inst_in;
        r_if_id_pc4   <= w_pc_plus4;
        r_if_id_valid <= 1'b1;
      end
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_flush_applied && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  // Stall watchdog: the flag is registered alongside the counter and mirrors its saturation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd_cnt        <= '0;
      r_stall_timeout <= 1'b0;
    end else begin
      r_wd_cnt        <= w_wd_next;
      r_stall_timeout <= (w_wd_next == WD_MAX);
    end
  end

  assign pc_out        = r_pc;
  assign if_id_inst    = r_if_id_inst;
  assign if_id_pc4     = r_if_id_pc4;
  assign if_id_valid   = r_if_id_valid;
  assign stall_cnt     = r_stall_cnt;
  assign flush_cnt     = r_flush_cnt;
  assign stall_timeout = r_stall_timeout;

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Bench for fetch_stage_ctrl: directed vectors push expected outputs into a queue.
// A separate monitor pops and compares after every clock edge and after any reset assertion.
// Every expected value below is hand-derived from the intended behaviour.
module tb_fetch_stage_ctrl;

  logic        clk;
  logic        rst_n;
  logic        pc_write;
  logic        ir_write;
  logic        flush;
  logic        pc_src;
  logic        jmp;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] inst_in;
  logic [31:0] pc_out;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic        stall_timeout;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        v;
    logic [15:0] s;
    logic [15:0] f;
    logic        t;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  fetch_stage_ctrl #(
    .RESET_PC (32'h0000_0000),
    .CNT_W    (16),
    .MAX_STALL(8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_write     (pc_write),
    .ir_write     (ir_write),
    .flush        (flush),
    .pc_src       (pc_src),
    .jmp          (jmp),
    .branch_target(branch_target),
    .jump_target  (jump_target),
    .inst_in      (inst_in),
    .pc_out       (pc_out),
    .if_id_inst   (if_id_inst),
    .if_id_pc4    (if_id_pc4),
    .if_id_valid  (if_id_valid),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
    .stall_timeout(stall_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s (vector %0d): got %h, expected %h", nm, idx, act, req);
    end
  endtask

  // Monitor: compares the oldest expectation after each edge or reset assertion.
  initial begin
    int idx;
    exp_t e;
    idx = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc_out",        idx, pc_out,                 e.pc);
        chk("if_id_inst",    idx, if_id_inst,             e.inst);
        chk("if_id_pc4",     idx, if_id_pc4,              e.pc4);
        chk("if_id_valid",   idx, 32'(if_id_valid),       32'(e.v));
        chk("stall_cnt",     idx, 32'(stall_cnt),         32'(e.s));
        chk("flush_cnt",     idx, 32'(flush_cnt),         32'(e.f));
        chk("stall_timeout", idx, 32'(stall_timeout),     32'(e.t));
        idx++;
      end
    end
  end

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] pc4,
                              input logic v, input logic [15:0] s, input logic [15:0] f, input logic t);
    exp_t e;
    e.pc = pc; e.inst = inst; e.pc4 = pc4; e.v = v; e.s = s; e.f = f; e.t = t;
    return e;
  endfunction

  // Apply one cycle of controls, queue the state expected after the next edge, then step to 2ns past that edge.
  task automatic cyc(input logic pw, input logic iw, input logic fl, input logic src, input logic j,
                     input logic [31:0] bt, input logic [31:0] jt, input logic [31:0] ins,
                     input logic [31:0] ep, input logic [31:0] ei, input logic [31:0] e4,
                     input logic ev, input logic [15:0] es, input logic [15:0] ef, input logic et);
    pc_write = pw; ir_write = iw; flush = fl; pc_src = src; jmp = j;
    branch_target = bt; jump_target = jt; inst_in = ins;
    q.push_back(mk(ep, ei, e4, ev, es, ef, et));
    @(posedge clk);
    #2;
  endtask

  initial begin
    int waited;
    rst_n = 1'b0;
    pc_write = 1'b1; ir_write = 1'b1; flush = 1'b0; pc_src = 1'b0; jmp = 1'b0;
    branch_target = '0; jump_target = '0; inst_in = 32'h1111_1111;
    // Reset state.
    q.push_back(mk(32'h0, 32'h0, 32'h0, 1'b0, 16'd0, 16'd0, 1'b0));
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Fetch sequence after reset release.
    cyc(1,1,0,0,0, 32'h0, 32'h0, 32'h1111_1111,  32'h4,  32'h1111_1111, 32'h4, 1, 0, 0, 0);
    cyc(1,1,0,0,0, 32'h0, 32'h0, 32'h2222_2222,  32'h8,  32'h2222_2222, 32'h8, 1, 0, 0, 0);
    // Three-cycle stall at PC=8.
    cyc(0,0,0,0,0, 32'h0, 32'h0, 32'h3333_3333,  32'h8,  32'h2222_2222, 32'h8, 1, 1, 0, 0);
    cyc(0,0,0,0,0, 32'h0, 32'h0, 32'h3333_3333,  32'h8,  32'h2222_2222, 32'h8, 1, 2, 0, 0);
    cyc(0,0,0,0,0, 32'h0, 32'h0, 32'h3333_3333,  32'h8,  32'h2222_2222, 32'h8, 1, 3, 0, 0);
    cyc(1,1,0,0,0, 32'h0, 32'h0, 32'h3333_3333,  32'hC,  32'h3333_3333, 32'hC, 1, 3, 0, 0);
    // Taken branch with flush.
    cyc(1,1,1,1,0, 32'h40, 32'h0, 32'h4444_4444, 32'h40, 32'h0,         32'h0, 0, 3, 1, 0);
    // Jump beats branch.
    cyc(1,1,0,1,1, 32'h40, 32'h100, 32'h5555_5555, 32'h100, 32'h5555_5555, 32'h44, 1, 3, 1, 0);
    // pc_write=0 overrides the redirect; IF/ID still loads and neither counter moves.
    cyc(0,1,0,1,1, 32'h40, 32'h200, 32'h6666_6666, 32'h100, 32'h6666_6666, 32'h104, 1, 3, 1, 0);
    // ir_write=0 with flush=1: IF/ID holds, no flush is counted, and PC advances.
    cyc(1,0,1,0,0, 32'h0, 32'h0, 32'h7777_7777,  32'h104, 32'h6666_6666, 32'h104, 1, 3, 1, 0);
    // Ten-cycle stall: the watchdog flag rises with the 8th stall.
    for (int k = 1; k <= 10; k++) begin
      cyc(0,0,0,0,0, 32'h0, 32'h0, 32'h7777_7777, 32'h104, 32'h6666_6666, 32'h104, 1,
          16'(3 + k), 16'd1, (k >= 8) ? 1'b1 : 1'b0);
    end
    // The first non-stall cycle clears the flag on its edge.
    cyc(1,1,0,0,0, 32'h0, 32'h0, 32'h8888_8888,  32'h108, 32'h8888_8888, 32'h108, 1, 13, 1, 0);
    // Jump to the top of the address space, then wrap to 0.
    cyc(1,1,0,0,1, 32'h0, 32'hFFFF_FFFC, 32'h9999_9999, 32'hFFFF_FFFC, 32'h9999_9999, 32'h10C, 1, 13, 1, 0);
    cyc(1,1,0,0,0, 32'h0, 32'h0, 32'hAAAA_AAAA,  32'h0,   32'hAAAA_AAAA, 32'h0,   1, 13, 1, 0);
    cyc(1,1,0,0,0, 32'h0, 32'h0, 32'hBBBB_BBBB,  32'h4,   32'hBBBB_BBBB, 32'h4,   1, 13, 1, 0);
    cyc(0,0,0,0,0, 32'h0, 32'h0, 32'hBBBB_BBBB,  32'h4,   32'hBBBB_BBBB, 32'h4,   1, 14, 1, 0);

    // Mid-stall asynchronous reset: checked 1ns after rst_n falls, before any edge.
    q.push_back(mk(32'h0, 32'h0, 32'h0, 1'b0, 16'd0, 16'd0, 1'b0));
    #3;
    rst_n = 1'b0;
    #2;
    // Still held in reset across the next edge.
    q.push_back(mk(32'h0, 32'h0, 32'h0, 1'b0, 16'd0, 16'd0, 1'b0));
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    cyc(1,1,0,0,0, 32'h0, 32'h0, 32'hCCCC_CCCC,  32'h4,   32'hCCCC_CCCC, 32'h4,   1, 0, 0, 0);

    // Bounded drain of the scoreboard.
    waited = 0;
    while (q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #2;
    chk("scoreboard_drained", 0, 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
